// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external ALU slice between two request lanes.
// Optional grant statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_share_arbiter #(
   parameter int unsigned DW    = 4,
   parameter int unsigned SELW  = 2,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [DW-1:0]    req0_a,
   input  logic [DW-1:0]    req0_b,
   input  logic [SELW-1:0]  req0_sel,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [DW-1:0]    req1_a,
   input  logic [DW-1:0]    req1_b,
   input  logic [SELW-1:0]  req1_sel,
   output logic [DW-1:0]    alu_a,
   output logic [DW-1:0]    alu_b,
   output logic [SELW-1:0]  alu_sel,
   output logic             alu_go,
   input  logic [DW:0]      alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [DW:0]      rsp_y,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   localparam int unsigned Y_W = DW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DW-1:0]   a;
      logic [DW-1:0]   b;
      logic [SELW-1:0] sel;
   } op_t;

   state_t         state_q, state_d;
   op_t            op_q, op_d;
   logic           alu_go_q, alu_go_d;
   logic           id_q, id_d;
   logic           last_gnt_q, last_gnt_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic           rsp_id_q, rsp_id_d;
   logic [Y_W-1:0] rsp_y_q, rsp_y_d;

   logic gnt_c;
   logic can_accept_c;
   logic accept_c;

   // Arbitration and handshake; ready is held low while reset is asserted.
   always_comb begin
      if (req0_valid && req1_valid) begin
         gnt_c = ~last_gnt_q;
      end else begin
         gnt_c = req1_valid;
      end
      can_accept_c = resetb & ((state_q == S_IDLE) | ((state_q == S_RESP) & rsp_ready));
      req0_ready   = can_accept_c & req0_valid & ~gnt_c;
      req1_ready   = can_accept_c & req1_valid & gnt_c;
      accept_c     = req0_ready | req1_ready;
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      alu_go_d    = 1'b0;
      id_d        = id_q;
      last_gnt_d  = last_gnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;

      if (accept_c) begin
         op_d       = gnt_c ? op_t'{req1_a, req1_b, req1_sel} : op_t'{req0_a, req0_b, req0_sel};
         id_d       = gnt_c;
         last_gnt_d = gnt_c;
         alu_go_d   = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept_c) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            rsp_y_d     = alu_y;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            // A consumed response frees the slot; a same-cycle accept goes straight to ISSUE.
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = accept_c ? S_ISSUE : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         alu_go_q    <= 1'b0;
         id_q        <= 1'b0;
         last_gnt_q  <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         alu_go_q    <= alu_go_d;
         id_q        <= id_d;
         last_gnt_q  <= last_gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
      end
   end

   assign alu_a     = op_q.a;
   assign alu_b     = op_q.b;
   assign alu_sel   = op_q.sel;
   assign alu_go    = alu_go_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_y     = rsp_y_q;

`ifdef ALU_ARB_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Saturating grant counters; clear has priority over a same-cycle grant.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (stats_clr) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end else begin
         if (req0_ready && (cnt0_q != CNT_MAX)) cnt0_d = cnt0_q + CNT_W'(1);
         if (req1_ready && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized scoreboard bench for alu_share_arbiter with a bench-side ALU.
// Expectations follow ALU_ARB_STATS_EN when it is defined for the build.
module tb_alu_share_arbiter;

   logic       clock;
   logic       resetb;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] req0_sel, req1_sel;
   logic [3:0] alu_a, alu_b;
   logic [1:0] alu_sel;
   logic       alu_go;
   logic [4:0] alu_y;
   logic       rsp_valid, rsp_ready, rsp_id;
   logic [4:0] rsp_y;
   logic       stats_clr;
   logic [7:0] gnt_cnt0, gnt_cnt1;

   alu_share_arbiter dut (
      .clock(clock), .resetb(resetb),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_go(alu_go), .alu_y(alu_y),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
      .stats_clr(stats_clr), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      case (s)
         2'd0:    return {1'b0, a} + {1'b0, b};
         2'd1:    return {1'b0, a} - {1'b0, b};
         2'd2:    return {1'b0, a & b};
         default: return {1'b0, a ^ b};
      endcase
   endfunction

   assign alu_y = ref_alu(alu_a, alu_b, alu_sel);

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic       id;
      logic [4:0] y;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic       model_last;
   logic       go_exp, rspv_exp, exp_lane;
   logic [3:0] ea, eb;
   logic [1:0] es;
   logic       hs0, hs1, hs0_seen, hs1_seen;
   int         acc_cnt = 0;
   int         m0, m1;

   // Monitor and reference model: the lane that wins, what it issues, what comes back.
   always @(negedge clock) begin
      if (!resetb) begin
         sb.delete();
         model_last = 1'b1;
         go_exp = 1'b0;
         rspv_exp = 1'b0;
         hs0_seen = 1'b0;
         hs1_seen = 1'b0;
         m0 = 0;
         m1 = 0;
      end else begin
         chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
         hs0 = req0_valid & req0_ready;
         hs1 = req1_valid & req1_ready;
         if (alu_go || (rsp_valid && !rsp_ready))
            chk("no_accept_busy", 32'(req0_ready | req1_ready), 32'd0);
         if (go_exp) begin
            chk("alu_go", 32'(alu_go), 32'd1);
            chk("alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'({ea, eb, es}));
         end else begin
            chk("alu_go_idle", 32'(alu_go), 32'd0);
         end
         if (rspv_exp) chk("rsp_latency", 32'(rsp_valid), 32'd1);
         rspv_exp = go_exp;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", 32'(rsp_id), 32'(e.id));
               chk("rsp_y", 32'(rsp_y), 32'(e.y));
            end
         end
         go_exp = 1'b0;
         if (hs0 || hs1) begin
            exp_lane = (req0_valid && req1_valid) ? !model_last : req1_valid;
            chk("gnt_lane", 32'(hs1), 32'(exp_lane));
            model_last = exp_lane;
            if (exp_lane) {ea, eb, es} = {req1_a, req1_b, req1_sel};
            else          {ea, eb, es} = {req0_a, req0_b, req0_sel};
            sb.push_back('{exp_lane, ref_alu(ea, eb, es)});
            go_exp = 1'b1;
            acc_cnt++;
         end
         hs0_seen = hs0;
         hs1_seen = hs1;
`ifdef ALU_ARB_STATS_EN
         chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m0));
         chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m1));
         if (stats_clr) begin
            m0 = 0;
            m1 = 0;
         end else begin
            if (hs0 && m0 < 255) m0++;
            if (hs1 && m1 < 255) m1++;
         end
`else
         chk("gnt_cnt0", 32'(gnt_cnt0), 32'd0);
         chk("gnt_cnt1", 32'(gnt_cnt1), 32'd0);
`endif
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_alu"}, 32'({alu_a, alu_b, alu_sel, alu_go}), 32'd0);
      chk({name, "_rsp"}, 32'({rsp_valid, rsp_id, rsp_y, req0_ready, req1_ready}), 32'd0);
      chk({name, "_cnt"}, 32'({gnt_cnt0, gnt_cnt1}), 32'd0);
   endtask

   task automatic do_op(input logic lane, input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
      logic ok;
      if (lane) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = s;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = s;
      end
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clock);
         ok = lane ? req1_ready : req0_ready;
      end
      if (!ok) chk("op_timeout", 32'd0, 32'd1);
      tick();
      if (lane) req1_valid = 1'b0;
      else      req0_valid = 1'b0;
   endtask

   logic [7:0] x3, x2, x255;

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ok;
`ifdef ALU_ARB_STATS_EN
      x3 = 8'd3; x2 = 8'd2; x255 = 8'd255;
`else
      x3 = 8'd0; x2 = 8'd0; x255 = 8'd0;
`endif
      resetb = 1'b0;
      {req0_valid, req1_valid, rsp_ready, stats_clr} = '0;
      {req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel} = '0;

      // Reset held while inputs toggle.
      for (int i = 0; i < 4; i++) begin
         tick();
         {req0_valid, req1_valid, rsp_ready, stats_clr} = 4'($urandom);
         {req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel} = 20'($urandom);
         #1;
         chk_all_zero("reset");
      end
      {req0_valid, req1_valid, rsp_ready, stats_clr} = '0;
      tick();
      resetb = 1'b1;
      @(negedge clock);
      chk("post_reset_rsp", 32'(rsp_valid), 32'd0);

      // Single add: 9 + 9.
      rsp_ready = 1'b1;
      tick();
      do_op(1'b0, 4'd9, 4'd9, 2'd0);
      @(negedge clock);
      chk("single_go", 32'({alu_go, alu_a, alu_b}), 32'({1'b1, 4'd9, 4'd9}));
      @(negedge clock);
      chk("single_rsp", 32'({rsp_valid, rsp_id, rsp_y}), 32'({1'b1, 1'b0, 5'b10010}));
      repeat (3) tick();

      // Contention: both lanes valid, back-to-back alternating grants.
      begin
         int base;
         base = acc_cnt;
         req0_valid = 1'b1; req1_valid = 1'b1;
         {req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel} = 20'($urandom);
         for (int i = 0; i < 20; i++) begin
            tick();
            if (hs0_seen) {req0_a, req0_b, req0_sel} = 10'($urandom);
            if (hs1_seen) {req1_a, req1_b, req1_sel} = 10'($urandom);
         end
         req0_valid = 1'b0; req1_valid = 1'b0;
         chk("b2b_accepts", 32'(acc_cnt - base), 32'd10);
      end
      repeat (3) tick();

      // Backpressure: response held, pending lane-1 request waits.
      rsp_ready = 1'b0;
      do_op(1'b0, 4'd3, 4'd7, 2'd1);
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clock);
         ok = rsp_valid;
      end
      if (!ok) chk("bp_rsp_timeout", 32'd0, 32'd1);
      tick();
      req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd10; req1_sel = 2'd3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_hold_rsp", 32'({rsp_valid, rsp_id, rsp_y}), 32'({1'b1, 1'b0, ref_alu(4'd3, 4'd7, 2'd1)}));
         chk("bp_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("bp_release_accept", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      repeat (4) tick();

      // Reset during ISSUE, then lane 0 wins the first contested grant.
      do_op(1'b1, 4'd5, 4'd6, 2'd2);
      #2;
      resetb = 1'b0;
      #1;
      chk_all_zero("midop_reset");
      repeat (2) @(posedge clock);
      #1;
      resetb = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      {req0_a, req0_b, req0_sel, req1_a, req1_b, req1_sel} = 20'($urandom);
      @(negedge clock);
      chk("first_gnt_lane0", 32'({req0_ready, req1_ready}), 32'b10);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) tick();

      // Randomized traffic with random backpressure and occasional clears.
      for (int i = 0; i < 400; i++) begin
         tick();
         if (!req0_valid || hs0_seen) begin
            req0_valid = ($urandom % 3) != 0;
            {req0_a, req0_b, req0_sel} = 10'($urandom);
         end else if ($urandom % 10 == 0) begin
            req0_valid = 1'b0;
         end
         if (!req1_valid || hs1_seen) begin
            req1_valid = ($urandom % 3) != 0;
            {req1_a, req1_b, req1_sel} = 10'($urandom);
         end else if ($urandom % 10 == 0) begin
            req1_valid = 1'b0;
         end
         rsp_ready = ($urandom % 4) != 0;
         stats_clr = ($urandom % 50) == 0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0; stats_clr = 1'b0; rsp_ready = 1'b1;
      repeat (4) tick();

      // Grant statistics: counts, saturation, clear.
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      for (int i = 0; i < 3; i++) do_op(1'b0, 4'($urandom), 4'($urandom), 2'($urandom));
      for (int i = 0; i < 2; i++) do_op(1'b1, 4'($urandom), 4'($urandom), 2'($urandom));
      repeat (3) tick();
      @(negedge clock);
      chk("stats_3_2", 32'({gnt_cnt0, gnt_cnt1}), 32'({x3, x2}));
      tick();
      for (int i = 0; i < 260; i++) do_op(1'b0, 4'($urandom), 4'($urandom), 2'($urandom));
      repeat (3) tick();
      @(negedge clock);
      chk("stats_sat", 32'({gnt_cnt0, gnt_cnt1}), 32'({x255, x2}));
      tick();
      stats_clr = 1'b1;
      tick();
      stats_clr = 1'b0;
      @(negedge clock);
      chk("stats_clr", 32'({gnt_cnt0, gnt_cnt1}), 32'd0);

      repeat (4) tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
